// File: rtl/board_renderer.sv
// ---------------------------------------------------------------------------
// board_renderer
//   Raster timing generator and tile-board pixel renderer. A free-running
//   hcnt/vcnt raster walks the screen. Each pixel passes through a two-stage
//   pipeline: stage 1 works out where the pixel sits on the board, and
//   stage 2 picks its colour. The sync outputs are delayed by the same two
//   cycles so they stay aligned with the colour outputs.
//
//   All inputs are copied into shadow registers once per frame, on the last
//   pixel of the last line. Rendering reads only the shadows, so a change
//   made mid-frame never shows before the next frame.
//
// Ports
//   pclk        in   pixel clock (only clock)
//   rstn        in   asynchronous active-low reset
//   state[1:0]  in   00 MENU, 01 PLAY, 10 SETTLE, 11 TEST
//   cursor_x/y  in   cursor column / row; out-of-range values draw no cursor
//   board_data  in   RGB444 per cell, cell i = row*COLS+col at [12*i +: 12]
//   red/green/blue out 4-bit colour channels
//   hs / vs     out  horizontal / vertical sync, asserted level SYNC_POL
// ---------------------------------------------------------------------------
module board_renderer #(
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 56,
    parameter int H_SYNC       = 120,
    parameter int H_BP         = 64,
    parameter int V_ACTIVE     = 600,
    parameter int V_FP         = 37,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 23,
    parameter bit SYNC_POL     = 1'b1,
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int CELL_PX      = 64,
    parameter int ORIGIN_X     = 144,
    parameter int ORIGIN_Y     = 44,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    pclk,
    input  logic                    rstn,
    input  logic [1:0]              state,
    input  logic [3:0]              cursor_x,
    input  logic [3:0]              cursor_y,
    input  logic [12*COLS*ROWS-1:0] board_data,
    output logic [3:0]              red,
    output logic [3:0]              green,
    output logic [3:0]              blue,
    output logic                    hs,
    output logic                    vs
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BOARD_W  = COLS * CELL_PX;
    localparam int BOARD_H  = ROWS * CELL_PX;
    localparam int HCW      = $clog2(H_TOTAL);
    localparam int VCW      = $clog2(V_TOTAL);
    localparam int CPW      = $clog2(CELL_PX);
    localparam int COLW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROWW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FCW      = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        MODE_MENU   = 2'b00,
        MODE_PLAY   = 2'b01,
        MODE_SETTLE = 2'b10,
        MODE_TEST   = 2'b11
    } mode_e;

    // -----------------------------------------------------------------------
    // Raster counters
    // -----------------------------------------------------------------------
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic           frame_end;

    assign frame_end = (hcnt_q == HCW'(H_TOTAL - 1)) && (vcnt_q == VCW'(V_TOTAL - 1));

    always_comb begin
        hcnt_d = hcnt_q + HCW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HCW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VCW'(V_TOTAL - 1)) ? '0 : vcnt_q + VCW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Frame shadows and cursor blink
    // -----------------------------------------------------------------------
    mode_e                   sh_state_q;
    logic [3:0]              sh_cx_q, sh_cy_q;
    logic [12*COLS*ROWS-1:0] sh_board_q;
    logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
    logic                    blink_q, blink_d;

    // The blink phase flips on the BLINK_FRAMES-th latch. It changes on the
    // same edge as the shadows, so the new phase applies to a whole frame.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_end) begin
            if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: pixel geometry
    // -----------------------------------------------------------------------
    int              hoff, voff;
    logic            s1_active_d, s1_hit_d;
    logic [COLW-1:0] s1_col_d;
    logic [ROWW-1:0] s1_row_d;
    logic [CPW-1:0]  s1_lx_d, s1_ly_d;
    logic            hs_raw, vs_raw;

    assign hoff = int'(hcnt_q) - ORIGIN_X;
    assign voff = int'(vcnt_q) - ORIGIN_Y;

    assign s1_active_d = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    assign s1_hit_d    = (hoff >= 0) && (hoff < BOARD_W) && (voff >= 0) && (voff < BOARD_H);
    // CELL_PX is a power of two, so the low bits of the offset give the
    // in-cell position and the bits above them give the cell index.
    assign s1_col_d    = COLW'(hoff >>> CPW);
    assign s1_row_d    = ROWW'(voff >>> CPW);
    assign s1_lx_d     = CPW'(hoff);
    assign s1_ly_d     = CPW'(voff);

    assign hs_raw = ((int'(hcnt_q) >= HS_START) && (int'(hcnt_q) < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = ((int'(vcnt_q) >= VS_START) && (int'(vcnt_q) < VS_END)) ? SYNC_POL : ~SYNC_POL;

    logic            s1_active_q, s1_hit_q;
    logic [COLW-1:0] s1_col_q;
    logic [ROWW-1:0] s1_row_q;
    logic [CPW-1:0]  s1_lx_q, s1_ly_q;
    logic [1:0]      hs_pipe_q, vs_pipe_q;

    // -----------------------------------------------------------------------
    // Stage 2: colour selection
    // -----------------------------------------------------------------------
    int          cell_idx;
    logic [11:0] cell_rgb;
    logic        cursor_valid, cursor_cell, cell_edge, cursor_px, grid_px;
    logic [11:0] rgb_q, rgb_d;

    assign cell_idx = int'(s1_row_q) * COLS + int'(s1_col_q);
    assign cell_rgb = sh_board_q[12*cell_idx +: 12];

    assign cursor_valid = (int'(sh_cx_q) < COLS) && (int'(sh_cy_q) < ROWS);
    assign cursor_cell  = (int'(s1_col_q) == int'(sh_cx_q)) && (int'(s1_row_q) == int'(sh_cy_q));
    // The outline is a 2-pixel ring just inside the cell border.
    assign cell_edge    = (int'(s1_lx_q) < 2) || (int'(s1_lx_q) >= CELL_PX - 2) ||
                          (int'(s1_ly_q) < 2) || (int'(s1_ly_q) >= CELL_PX - 2);
    assign cursor_px    = blink_q && cursor_valid && cursor_cell && cell_edge;

    // A grid line runs along the left and top of every cell. The closing
    // line on the right and bottom of the board is added separately.
    assign grid_px = (s1_lx_q == '0) || (s1_ly_q == '0) ||
                     ((int'(s1_col_q) == COLS - 1) && (int'(s1_lx_q) == CELL_PX - 1)) ||
                     ((int'(s1_row_q) == ROWS - 1) && (int'(s1_ly_q) == CELL_PX - 1));

    always_comb begin
        rgb_d = 12'h000;
        if (s1_active_q) begin
            case (sh_state_q)
                MODE_MENU: rgb_d = 12'h00F;
                MODE_TEST: rgb_d = 12'hFFF;
                MODE_PLAY: begin
                    if (s1_hit_q) begin
                        if (cursor_px)    rgb_d = 12'hFFF;
                        else if (grid_px) rgb_d = 12'h888;
                        else              rgb_d = cell_rgb;
                    end
                end
                MODE_SETTLE: begin
                    if (!s1_hit_q)    rgb_d = 12'hF00;
                    else if (grid_px) rgb_d = 12'h888;
                    else              rgb_d = {1'b0, cell_rgb[11:9], 1'b0, cell_rgb[7:5],
                                               1'b0, cell_rgb[3:1]};
                end
                default: rgb_d = 12'h000;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            sh_state_q  <= MODE_MENU;
            sh_cx_q     <= '0;
            sh_cy_q     <= '0;
            sh_board_q  <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            s1_active_q <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s1_lx_q     <= '0;
            s1_ly_q     <= '0;
            hs_pipe_q   <= {2{~SYNC_POL}};
            vs_pipe_q   <= {2{~SYNC_POL}};
            rgb_q       <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            if (frame_end) begin
                sh_state_q <= mode_e'(state);
                sh_cx_q    <= cursor_x;
                sh_cy_q    <= cursor_y;
                sh_board_q <= board_data;
            end
            s1_active_q <= s1_active_d;
            s1_hit_q    <= s1_hit_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            s1_lx_q     <= s1_lx_d;
            s1_ly_q     <= s1_ly_d;
            hs_pipe_q   <= {hs_pipe_q[0], hs_raw};
            vs_pipe_q   <= {vs_pipe_q[0], vs_raw};
            rgb_q       <= rgb_d;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
    assign hs    = hs_pipe_q[1];
    assign vs    = vs_pipe_q[1];

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer. It uses a reduced raster so that
// whole frames fit in a short run. Every output pixel is compared with a
// frame-level reference model, and selected pixels are also compared with
// fixed expected colours.
module tb_board_renderer;

    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
    localparam int VA = 40, VFP = 2, VSY = 3, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam bit POL = 1'b1;
    localparam int COLS = 4, ROWS = 4, CP = 8, OX = 4, OY = 3, BF = 2;
    localparam int NC = COLS * ROWS;

    logic              pclk = 1'b0;
    logic              rstn = 1'b0;
    logic [1:0]        state = 2'b00;
    logic [3:0]        cursor_x = 4'd0, cursor_y = 4'd0;
    logic [11:0]       cells [NC];
    logic [12*NC-1:0]  board_data;
    logic [3:0]        red, green, blue;
    logic              hs, vs;

    board_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(POL), .COLS(COLS), .ROWS(ROWS), .CELL_PX(CP),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLINK_FRAMES(BF)
    ) dut (
        .pclk(pclk), .rstn(rstn), .state(state),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .board_data(board_data),
        .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs)
    );

    always #5 pclk = ~pclk;

    always_comb begin
        board_data = '0;
        for (int i = 0; i < NC; i++) board_data[12*i +: 12] = cells[i];
    end

    // ---------------- reference model ----------------
    int          mh, mv, mf;
    int          m_state, m_cx, m_cy;
    logic [11:0] m_cells [NC];
    logic [11:0] p_rgb;
    logic        p_hs, p_vs;
    int          p_h, p_v;

    int          ntotal = 0, npass = 0;
    int          dir_n = 0;
    int          dir_h [4], dir_v [4];
    logic [11:0] dir_c [4];
    bit          fff_en = 1'b0;
    int          fff_seen = 0;

    function automatic logic [11:0] ref_pix(int h, int v);
        int bx, by, c, r, lx, ly;
        bit hit, phase;
        logic [11:0] cc;
        if (h >= HA || v >= VA) return 12'h000;
        if (m_state == 0) return 12'h00F;
        if (m_state == 3) return 12'hFFF;
        bx  = h - OX;
        by  = v - OY;
        hit = (bx >= 0) && (bx < COLS*CP) && (by >= 0) && (by < ROWS*CP);
        if (!hit) return (m_state == 2) ? 12'hF00 : 12'h000;
        c  = bx / CP;  r  = by / CP;
        lx = bx % CP;  ly = by % CP;
        cc = m_cells[r*COLS + c];
        phase = ((mf / BF) % 2) == 0;
        if (m_state == 1 && phase && m_cx == c && m_cy == r &&
            (lx < 2 || lx >= CP-2 || ly < 2 || ly >= CP-2)) return 12'hFFF;
        if (lx == 0 || ly == 0 || bx == COLS*CP-1 || by == ROWS*CP-1) return 12'h888;
        if (m_state == 2) return {cc[11:8] >> 1, cc[7:4] >> 1, cc[3:0] >> 1};
        return cc;
    endfunction

    function automatic logic [11:0] rnd_rgb();
        logic [11:0] c;
        c = 12'($urandom);
        if (c == 12'hFFF) c = 12'hFFE;
        return c;
    endfunction

    task automatic reset_model();
        mh = 0; mv = 0; mf = 0;
        m_state = 0; m_cx = 0; m_cy = 0;
        for (int i = 0; i < NC; i++) m_cells[i] = 12'h000;
        p_rgb = 12'h000; p_hs = !POL; p_vs = !POL; p_h = -1; p_v = -1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s at (%0d,%0d): observed %h, expected %h", tag, p_h, p_v, obs, exp);
    endtask

    task automatic chk_rst();
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_hs", {11'b0, hs}, {11'b0, !POL});
        chk("reset_vs", {11'b0, vs}, {11'b0, !POL});
    endtask

    // One pixel clock: predict the pixel at the model counters, apply the
    // frame latch, advance, then compare the DUT output against the pixel
    // predicted on the previous call (two cycles from counter to pins).
    task automatic tick();
        logic [11:0] n_rgb;
        logic        n_hs, n_vs;
        int          n_h, n_v;
        n_rgb = ref_pix(mh, mv);
        n_hs  = (mh >= HA+HFP && mh < HA+HFP+HSY) ? POL : !POL;
        n_vs  = (mv >= VA+VFP && mv < VA+VFP+VSY) ? POL : !POL;
        n_h = mh; n_v = mv;
        if (mh == HT-1 && mv == VT-1) begin
            m_state = int'(state); m_cx = int'(cursor_x); m_cy = int'(cursor_y);
            for (int i = 0; i < NC; i++) m_cells[i] = cells[i];
            mf++;
        end
        if (mh == HT-1) begin
            mh = 0;
            mv = (mv == VT-1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        @(posedge pclk); #1;
        chk("pixel_rgb", {red, green, blue}, p_rgb);
        chk("hsync", {11'b0, hs}, {11'b0, p_hs});
        chk("vsync", {11'b0, vs}, {11'b0, p_vs});
        for (int i = 0; i < dir_n; i++)
            if (p_h == dir_h[i] && p_v == dir_v[i]) chk("directed_pixel", {red, green, blue}, dir_c[i]);
        if (fff_en && p_h >= OX && p_h < OX+COLS*CP && p_v >= OY && p_v < OY+ROWS*CP &&
            {red, green, blue} == 12'hFFF) fff_seen++;
        p_rgb = n_rgb; p_hs = n_hs; p_vs = n_vs; p_h = n_h; p_v = n_v;
    endtask

    task automatic run_to(input int h, input int v);
        int guard = 0;
        while (!(mh == h && mv == v) && guard < HT*VT) begin
            tick();
            guard++;
        end
    endtask

    task automatic run_frame();
        tick();
        run_to(0, 0);
    endtask

    task automatic set_dir(input int i, input int h, input int v, input logic [11:0] c);
        dir_h[i] = h; dir_v[i] = v; dir_c[i] = c;
    endtask

    task automatic rand_inputs();
        state    = 2'($urandom_range(0, 3));
        cursor_x = 4'($urandom_range(0, 9));
        cursor_y = 4'($urandom_range(0, 9));
        for (int i = 0; i < NC; i++) cells[i] = rnd_rgb();
    endtask

    initial begin
        for (int i = 0; i < NC; i++) cells[i] = 12'h000;
        reset_model();
        #1 chk_rst();
        repeat (3) begin @(posedge pclk); #1; chk_rst(); end
        rstn = 1'b1;

        // Frame 0: reset shadow is MENU. PLAY inputs arrive mid-frame.
        run_to(0, VA/2);
        state = 2'b01; cursor_x = 4'd3; cursor_y = 4'd3;
        for (int i = 0; i < NC; i++) cells[i] = rnd_rgb();
        cells[0] = 12'hF00; cells[15] = 12'h0A5;
        run_frame();

        // Frames 1..4: PLAY with the cursor at (3,3) and BLINK_FRAMES=2.
        // The outline shows in frames 1 and 4 and is hidden in frames 2 and 3.
        for (int f = 1; f <= 4; f++) begin
            set_dir(0, OX+2, OY+2, 12'hF00);
            set_dir(1, OX, OY+2, 12'h888);
            set_dir(2, OX+3*CP+1, OY+3*CP+2, (f == 2 || f == 3) ? 12'h0A5 : 12'hFFF);
            set_dir(3, 1, 1, 12'h000);
            dir_n = 4;
            run_to(0, VA/2);
            for (int i = 1; i < NC-1; i++) cells[i] = rnd_rgb();
            if (f == 4) begin cursor_x = 4'd8; cursor_y = 4'd2; end
            run_frame();
        end

        // Frame 5: cursor column out of range -> no outline on the board.
        dir_n = 0; fff_en = 1'b1; fff_seen = 0;
        run_to(0, VA/2);
        cells[0] = 12'hFA6; cells[12] = 12'h3C9; cursor_x = 4'd3; cursor_y = 4'd3;
        run_frame();
        fff_en = 1'b0;
        chk("no_cursor_fff", 12'(fff_seen), 12'h000);

        // Frame 6: switch to SETTLE at mid-frame; the rest stays PLAY.
        set_dir(0, OX+2, OY+2, 12'hFA6);
        set_dir(1, OX+2, OY+3*CP+2, 12'h3C9);
        set_dir(2, 1, 30, 12'h000);
        set_dir(3, 1, 1, 12'h000);
        dir_n = 4;
        run_to(0, VA/2);
        state = 2'b10;
        run_frame();

        // Frame 7: SETTLE is visible.
        set_dir(0, OX+2, OY+2, 12'h753);
        set_dir(1, 1, 1, 12'hF00);
        set_dir(2, OX+2, OY+3*CP+2, 12'h164);
        set_dir(3, OX, OY+2, 12'h888);
        run_to(0, VA/2);
        state = 2'b11;
        run_frame();

        // Frame 8: TEST.
        set_dir(0, 1, 1, 12'hFFF);
        set_dir(1, HA+1, 1, 12'h000);
        set_dir(2, OX+2, OY+2, 12'hFFF);
        dir_n = 3;
        run_frame();
        dir_n = 0;

        // Frames 9..11: random inputs changed at random times.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(50, 800)) tick();
                rand_inputs();
            end
            run_frame();
        end

        // Reset asserted mid-frame: outputs clear at once and the raster restarts.
        run_to(10, 17);
        rstn = 1'b0;
        #1 chk_rst();
        repeat (2) begin @(posedge pclk); #1; chk_rst(); end
        reset_model();
        rstn = 1'b1;
        run_frame();
        rand_inputs();
        state = 2'b01;
        run_frame();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
